// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, slave state enum and byte-lane strobe helper
// used by the SRAM slave and its storage array.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } slv_state_e;

  // Little-endian lane strobe; illegal sizes yield no lanes.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] addr);
    logic [3:0] mask;
    case (size)
      HSIZE_BYTE: mask = 4'b0001 << addr;
      HSIZE_HALF: mask = addr[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: mask = 4'b1111;
      default:    mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/sram_bw.sv
// Byte-writable 32-bit word array: strobed synchronous write, combinational read.
// Contents are never reset.
module sram_bw #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [3:0]    strb,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave with configurable wait states and byte/half/word writes.
// Optional window range check enabled by defining AHB_SLV_RANGE_CHECK_EN.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          MEM_DEPTH   = 1024,
  parameter int          WAIT_STATES = 0
) (
  input  logic        I_SLV_HCLK,
  input  logic        I_SLV_HRESET_N,
  input  logic        I_SLV_HSEL,
  input  logic [31:0] I_SLV_HADDR,
  input  logic [1:0]  I_SLV_HTRANS,
  input  logic        I_SLV_HWRITE,
  input  logic [2:0]  I_SLV_HSIZE,
  input  logic [2:0]  I_SLV_HBURST,
  input  logic [31:0] I_SLV_HWDATA,
  input  logic        I_SLV_HREADY,
  output logic [31:0] O_SLV_HRDATA,
  output logic        O_SLV_HREADYOUT,
  output logic [1:0]  O_SLV_HRESP
);

  localparam int         AW        = $clog2(MEM_DEPTH);
  localparam logic [2:0] WAIT_LOAD = 3'(WAIT_STATES - 1);

  slv_state_e    state_q, state_d;
  logic [2:0]    wait_cnt_q, wait_cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [1:0]    boff_q, boff_d;
  logic [2:0]    size_q, size_d;
  logic          write_q, write_d;
  logic [31:0]   hrdata_q, hrdata_d;
  logic          hreadyout_q, hreadyout_d;
  logic [1:0]    hresp_q, hresp_d;

  logic          accept;
  logic          illegal;
  logic          out_of_range;
  logic [31:0]   offset;
  logic [31:0]   mem_rdata;
  logic          mem_we;
  logic          unused_ok;

  assign accept = I_SLV_HSEL & I_SLV_HREADY & I_SLV_HTRANS[1];
  assign offset = I_SLV_HADDR - ADDR_BASE;

`ifdef AHB_SLV_RANGE_CHECK_EN
  logic [32:0] limit;
  assign limit        = {1'b0, ADDR_BASE} + 33'(4 * MEM_DEPTH);
  assign out_of_range = (I_SLV_HADDR < ADDR_BASE) || ({1'b0, I_SLV_HADDR} >= limit);
`else
  assign out_of_range = 1'b0;
`endif

  assign illegal = (I_SLV_HSIZE > HSIZE_WORD)
                || ((I_SLV_HSIZE == HSIZE_HALF) && I_SLV_HADDR[0])
                || ((I_SLV_HSIZE == HSIZE_WORD) && (I_SLV_HADDR[1:0] != 2'b00))
                || out_of_range;

  // Read data is live from the array during a read ACCESS and held otherwise.
  assign O_SLV_HRDATA    = (state_q == ST_ACCESS && !write_q) ? mem_rdata : hrdata_q;
  assign O_SLV_HREADYOUT = hreadyout_q;
  assign O_SLV_HRESP     = hresp_q;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    idx_d       = idx_q;
    boff_d      = boff_q;
    size_d      = size_q;
    write_d     = write_q;
    hreadyout_d = hreadyout_q;
    hresp_d     = hresp_q;
    hrdata_d    = O_SLV_HRDATA;

    case (state_q)
      ST_WAIT: begin
        if (wait_cnt_q == 3'd0) begin
          state_d     = ST_ACCESS;
          hreadyout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q - 3'd1;
        end
      end
      ST_ERR1: begin
        state_d     = ST_ERR2;
        hreadyout_d = 1'b1;
        hresp_d     = HRESP_ERROR;
      end
      // IDLE, ACCESS and ERR2 all sample the pipelined address phase.
      default: begin
        if (accept) begin
          idx_d   = offset[AW+1:2];
          boff_d  = I_SLV_HADDR[1:0];
          size_d  = I_SLV_HSIZE;
          write_d = I_SLV_HWRITE;
          if (illegal) begin
            state_d     = ST_ERR1;
            hreadyout_d = 1'b0;
            hresp_d     = HRESP_ERROR;
          end else if (WAIT_STATES == 0) begin
            state_d     = ST_ACCESS;
            hreadyout_d = 1'b1;
            hresp_d     = HRESP_OKAY;
          end else begin
            state_d     = ST_WAIT;
            wait_cnt_d  = WAIT_LOAD;
            hreadyout_d = 1'b0;
            hresp_d     = HRESP_OKAY;
          end
        end else begin
          state_d     = ST_IDLE;
          hreadyout_d = 1'b1;
          hresp_d     = HRESP_OKAY;
        end
      end
    endcase
  end

  always_ff @(posedge I_SLV_HCLK) begin
    if (!I_SLV_HRESET_N) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= 3'd0;
      idx_q       <= '0;
      boff_q      <= 2'b00;
      size_q      <= HSIZE_BYTE;
      write_q     <= 1'b0;
      hrdata_q    <= 32'h0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      idx_q       <= idx_d;
      boff_q      <= boff_d;
      size_q      <= size_d;
      write_q     <= write_d;
      hrdata_q    <= hrdata_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
    end
  end

  // A reset landing on the ACCESS edge must not commit the write.
  assign mem_we = (state_q == ST_ACCESS) && write_q && I_SLV_HRESET_N;

  sram_bw #(
    .DEPTH (MEM_DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (I_SLV_HCLK),
    .addr  (idx_q),
    .we    (mem_we),
    .strb  (lane_mask(size_q, boff_q)),
    .wdata (I_SLV_HWDATA),
    .rdata (mem_rdata)
  );

  assign unused_ok = ^{I_SLV_HBURST, I_SLV_HTRANS[0], offset};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench for ahb_sram_slave: a zero-wait and a two-wait instance share
// one pipelined AHB master; expectations come from a per-instance memory model.
module tb_ahb_sram_slave;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          DEPTH = 1024;

  typedef struct {
    logic [31:0] addr;
    bit          write;
    logic [2:0]  size;
    logic [31:0] wdata;
    int          tgt;
    logic [1:0]  trans;
    logic [2:0]  burst;
  } beat_t;

  typedef struct {
    string       tag;
    bit          isRead;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          waits;
  } exp_t;

  logic        clock = 1'b0;
  logic        hresetN;
  logic        sel0, sel2;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        hreadyBus;
  logic [31:0] hrdata0, hrdata2;
  logic        hro0, hro2;
  logic [1:0]  hresp0, hresp2;

  bit          dpValid = 1'b0;
  int          dpTgt = 0;

  beat_t       beats[$];
  exp_t        sb[$];
  logic [31:0] model [2][DEPTH];

  int          checkCount = 0;
  int          passCount  = 0;

  always #5 clock = ~clock;

  assign hreadyBus = dpValid ? ((dpTgt == 1) ? hro2 : hro0) : 1'b1;

  ahb_sram_slave #(.ADDR_BASE(BASE), .MEM_DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
    .I_SLV_HCLK(clock), .I_SLV_HRESET_N(hresetN), .I_SLV_HSEL(sel0),
    .I_SLV_HADDR(haddr), .I_SLV_HTRANS(htrans), .I_SLV_HWRITE(hwrite),
    .I_SLV_HSIZE(hsize), .I_SLV_HBURST(hburst), .I_SLV_HWDATA(hwdata),
    .I_SLV_HREADY(hreadyBus), .O_SLV_HRDATA(hrdata0),
    .O_SLV_HREADYOUT(hro0), .O_SLV_HRESP(hresp0)
  );

  ahb_sram_slave #(.ADDR_BASE(BASE), .MEM_DEPTH(DEPTH), .WAIT_STATES(2)) dut2 (
    .I_SLV_HCLK(clock), .I_SLV_HRESET_N(hresetN), .I_SLV_HSEL(sel2),
    .I_SLV_HADDR(haddr), .I_SLV_HTRANS(htrans), .I_SLV_HWRITE(hwrite),
    .I_SLV_HSIZE(hsize), .I_SLV_HBURST(hburst), .I_SLV_HWDATA(hwdata),
    .I_SLV_HREADY(hreadyBus), .O_SLV_HRDATA(hrdata2),
    .O_SLV_HREADYOUT(hro2), .O_SLV_HRESP(hresp2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  function automatic bit beatIllegal(input logic [31:0] addr, input logic [2:0] size);
    bit bad;
    bad = (size > 3'd2) || (size == 3'd1 && addr[0] == 1'b1) || (size == 3'd2 && addr[1:0] != 2'b00);
`ifdef AHB_SLV_RANGE_CHECK_EN
    if (addr < BASE || {1'b0, addr} >= {1'b0, BASE} + 33'(4 * DEPTH)) bad = 1'b1;
`endif
    return bad;
  endfunction

  function automatic int modelIndex(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    return int'(off >> 2) % DEPTH;
  endfunction

  task automatic queueBeat(input logic [31:0] addr, input bit write, input logic [2:0] size,
                           input logic [31:0] wdata, input int tgt,
                           input logic [1:0] trans, input logic [2:0] burst);
    beat_t b;
    b.addr = addr; b.write = write; b.size = size; b.wdata = wdata;
    b.tgt = tgt; b.trans = trans; b.burst = burst;
    beats.push_back(b);
  endtask

  task automatic driveIdle();
    sel0 = 1'b0; sel2 = 1'b0; htrans = 2'b00; haddr = 32'h0;
    hwrite = 1'b0; hsize = 3'd0; hburst = 3'd0;
  endtask

  // Drive the next address phase and push its expected outcome.
  task automatic loadNext(output bit valid, output beat_t b);
    exp_t e;
    int   idx, nbytes, off;
    valid = 1'b0;
    b = '{default: '0};
    if (beats.size() == 0) begin
      driveIdle();
      return;
    end
    b = beats.pop_front();
    valid = 1'b1;
    sel0 = (b.tgt == 0); sel2 = (b.tgt == 1);
    haddr = b.addr; htrans = b.trans; hwrite = b.write; hsize = b.size; hburst = b.burst;
    e.tag = $sformatf("%s%0d@%h", b.write ? "wr" : "rd", b.tgt == 1 ? 2 : 0, b.addr);
    e.isRead = 1'b0;
    e.rdata = 32'h0;
    if (beatIllegal(b.addr, b.size)) begin
      e.resp = 2'b01;
      e.waits = 1;
    end else begin
      e.resp = 2'b00;
      e.waits = (b.tgt == 1) ? 2 : 0;
      idx = modelIndex(b.addr);
      if (b.write) begin
        nbytes = 1 << b.size;
        off = int'(b.addr[1:0]);
        for (int k = 0; k < 4; k++)
          if (k >= off && k < off + nbytes) model[b.tgt][idx][8*k +: 8] = b.wdata[8*k +: 8];
      end else begin
        e.isRead = 1'b1;
        e.rdata = model[b.tgt][idx];
      end
    end
    sb.push_back(e);
  endtask

  // Pipelined master: runs all queued beats; entered and left at posedge+1.
  task automatic applyStimulus();
    beat_t       ap, nb;
    bit          apValid, nv, hr;
    int          waitCnt = 0;
    int          budget = 500;
    exp_t        e;
    logic [1:0]  resp;
    logic [31:0] rdata;
    loadNext(apValid, ap);
    while ((apValid || dpValid) && budget > 0) begin
      @(negedge clock);
      hr = hreadyBus;
      if (dpValid) begin
        resp  = (dpTgt == 1) ? hresp2 : hresp0;
        rdata = (dpTgt == 1) ? hrdata2 : hrdata0;
        if (!hr) begin
          waitCnt++;
          if (sb.size() > 0) checkOutput({sb[0].tag, "_wresp"}, 32'(resp), 32'(sb[0].resp));
        end else if (sb.size() == 0) begin
          checkOutput("scoreboard_empty", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          checkOutput({e.tag, "_waits"}, 32'(waitCnt), 32'(e.waits));
          checkOutput({e.tag, "_resp"}, 32'(resp), 32'(e.resp));
          if (e.isRead) checkOutput({e.tag, "_data"}, rdata, e.rdata);
        end
      end
      @(posedge clock); #1;
      if (dpValid && hr) dpValid = 1'b0;
      if (hr && apValid) begin
        dpValid = 1'b1;
        dpTgt = ap.tgt;
        hwdata = ap.wdata;
        waitCnt = 0;
        loadNext(nv, nb);
        apValid = nv;
        ap = nb;
      end
      budget--;
    end
    checkOutput("stimulus_done", {31'b0, apValid || dpValid}, 32'd0);
  endtask

  initial begin
    hresetN = 1'b0;
    hwdata = 32'h0;
    driveIdle();
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("reset_ready0", {31'b0, hro0}, 32'd1);
    checkOutput("reset_resp0", 32'(hresp0), 32'd0);
    checkOutput("reset_rdata0", hrdata0, 32'h0);
    checkOutput("reset_ready2", {31'b0, hro2}, 32'd1);
    checkOutput("reset_rdata2", hrdata2, 32'h0);
    hresetN = 1'b1;
    @(posedge clock); #1;

    // Zero-wait word write then immediate read-back.
    queueBeat(32'h10, 1, 3'd2, 32'hDEAD_BEEF, 0, 2'b10, 3'd0);
    queueBeat(32'h10, 0, 3'd2, 32'h0, 0, 2'b10, 3'd0);
    // Byte and halfword lane merging into word 0.
    queueBeat(32'h00, 1, 3'd2, 32'h0000_0000, 0, 2'b10, 3'd0);
    queueBeat(32'h01, 1, 3'd0, 32'h0000_AA00, 0, 2'b10, 3'd0);
    queueBeat(32'h02, 1, 3'd1, 32'h1234_0000, 0, 2'b10, 3'd0);
    queueBeat(32'h00, 0, 3'd2, 32'h0, 0, 2'b10, 3'd0);
    applyStimulus();

    // Illegal beats: misaligned word/half, oversize; memory must be untouched.
    queueBeat(32'h03, 0, 3'd2, 32'h0, 0, 2'b10, 3'd0);
    queueBeat(32'h12, 1, 3'd2, 32'hFFFF_FFFF, 0, 2'b10, 3'd0);
    queueBeat(32'h11, 1, 3'd1, 32'hFFFF_FFFF, 0, 2'b10, 3'd0);
    queueBeat(32'h10, 1, 3'd3, 32'hFFFF_FFFF, 0, 2'b10, 3'd0);
    queueBeat(32'h10, 0, 3'd2, 32'h0, 0, 2'b10, 3'd0);
    applyStimulus();
    @(negedge clock);
    checkOutput("after_err_ready0", {31'b0, hro0}, 32'd1);
    checkOutput("after_err_resp0", 32'(hresp0), 32'd0);
    @(posedge clock); #1;

    // Out-of-window write: wraps onto word 0 unless range checking is built in.
    queueBeat(32'h1000, 1, 3'd2, 32'h5A5A_0001, 0, 2'b10, 3'd0);
    queueBeat(32'h0000, 0, 3'd2, 32'h0, 0, 2'b10, 3'd0);
    applyStimulus();

    // INCR4 write and read with two wait states, then preset word 0x40.
    for (int i = 0; i < 4; i++)
      queueBeat(32'h20 + 32'(4 * i), 1, 3'd2, 32'(i + 1), 1, (i == 0) ? 2'b10 : 2'b11, 3'd3);
    for (int i = 0; i < 4; i++)
      queueBeat(32'h20 + 32'(4 * i), 0, 3'd2, 32'h0, 1, (i == 0) ? 2'b10 : 2'b11, 3'd3);
    queueBeat(32'h40, 1, 3'd2, 32'h0BAD_F00D, 1, 2'b10, 3'd0);
    applyStimulus();

    // Reset in the WAIT of a write to 0x40 abandons it.
    sel2 = 1'b1; haddr = 32'h40; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
    @(posedge clock); #1;
    driveIdle();
    hwdata = 32'hFFFF_0000;
    dpValid = 1'b1; dpTgt = 1;
    @(negedge clock);
    checkOutput("rst_mid_wait_ready", {31'b0, hro2}, 32'd0);
    hresetN = 1'b0;
    @(posedge clock); #1;
    dpValid = 1'b0;
    @(negedge clock);
    checkOutput("rst_mid_ready", {31'b0, hro2}, 32'd1);
    checkOutput("rst_mid_resp", 32'(hresp2), 32'd0);
    checkOutput("rst_mid_rdata", hrdata2, 32'h0);
    hresetN = 1'b1;
    @(posedge clock); #1;
    queueBeat(32'h40, 0, 3'd2, 32'h0, 1, 2'b10, 3'd0);
    applyStimulus();

    // BUSY with HSEL high is not an access.
    sel2 = 1'b1; haddr = 32'h20; htrans = 2'b01; hwrite = 1'b1; hsize = 3'd2;
    hwdata = 32'hCAFE_CAFE;
    @(posedge clock); #1;
    driveIdle();
    @(negedge clock);
    checkOutput("busy_ready", {31'b0, hro2}, 32'd1);
    checkOutput("busy_resp", 32'(hresp2), 32'd0);
    @(posedge clock); #1;
    queueBeat(32'h20, 0, 3'd2, 32'h0, 1, 2'b10, 3'd0);
    applyStimulus();

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
